// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : router_pkg
// Description : Shared constants and types for the router register block.
// Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    localparam int CHK_XOR    = 0;
    localparam int CHK_SUM    = 1;
    localparam int DEF_DW     = 8;
    localparam int DEF_ADDR_W = 2;

    // Source selected for the next dout value.
    typedef enum logic [1:0] {
        SEL_KEEP   = 2'd0,
        SEL_HEADER = 2'd1,
        SEL_DATA   = 2'd2,
        SEL_HOLD   = 2'd3
    } dout_sel_e;

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_chk_acc.sv
`default_nettype none
// ============================================================================
// Module      : router_chk_acc
// Description : Running packet checksum, XOR parity or wrap-around sum.
// Revision    : 1.0 - initial release
// ============================================================================
module router_chk_acc
    import router_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int CHK_MODE = CHK_XOR
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          fold_en,
    input  logic [DW-1:0] fold_val,
    output logic [DW-1:0] acc
);

    logic [DW-1:0] r_acc;
    logic [DW-1:0] w_folded;

    generate
        if (CHK_MODE == CHK_XOR) begin : g_xor
            assign w_folded = r_acc ^ fold_val;
        end else begin : g_sum
            // Carry out of the top bit is dropped on purpose.
            assign w_folded = r_acc + fold_val;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (clr) begin
            r_acc <= '0;
        end else if (fold_en) begin
            r_acc <= w_folded;
        end
    end

    assign acc = r_acc;

endmodule : router_chk_acc
`default_nettype wire

// File: rtl/router_reg_param.sv
`default_nettype none
// ============================================================================
// Module      : router_reg_param
// Description : Router datapath registers: header, hold, dout, checksum/err.
//               Define ROUTER_REG_ERR_CNT_EN to build the saturating err_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module router_reg_param
    import router_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_CH   = 3,
    parameter int CHK_MODE = CHK_XOR,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             laf_state,
    input  logic             full_state,
    input  logic             rst_int_reg,
    input  logic [DW-1:0]    d_in,
    output logic [DW-1:0]    dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err,
    output logic             hdr_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [DW-1:0] r_header;
    logic [DW-1:0] r_hold;
    logic [DW-1:0] r_dout;
    logic [DW-1:0] r_chk;
    logic          r_parity_done;
    logic          r_low_pkt_valid;
    logic          r_err;
    logic          r_hdr_err;

    logic [DW-1:0] w_acc;
    logic [DW-1:0] w_fold_val;
    logic [31:0]   w_addr;
    logic          w_addr_ok;
    logic          w_hdr_seen;
    logic          w_fold_hdr;
    logic          w_fold_en;
    logic          w_chk_cap;
    logic          w_err_next;
    dout_sel_e     w_dout_sel;

    assign w_addr     = 32'(d_in[ADDR_W-1:0]);
    assign w_addr_ok  = (w_addr < $unsigned(NUM_CH));
    assign w_hdr_seen = detect_add & pkt_valid;

    // Checksum byte arrives either directly in load or, after a FIFO stall, via laf.
    assign w_chk_cap  = (ld_state & ~pkt_valid & ~fifo_full)
                      | (laf_state & r_low_pkt_valid & ~r_parity_done);

    assign w_fold_hdr = lfd_state & pkt_valid;
    assign w_fold_en  = w_fold_hdr | (ld_state & pkt_valid & ~full_state);
    assign w_fold_val = w_fold_hdr ? r_header : d_in;

    assign w_err_next = r_parity_done & (w_acc != r_chk);

    router_chk_acc #(
        .DW       (DW),
        .CHK_MODE (CHK_MODE)
    ) u_chk_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (detect_add),
        .fold_en  (w_fold_en),
        .fold_val (w_fold_val),
        .acc      (w_acc)
    );

    always_comb begin
        w_dout_sel = SEL_KEEP;
        if (lfd_state) begin
            w_dout_sel = SEL_HEADER;
        end else if (ld_state && !fifo_full) begin
            w_dout_sel = SEL_DATA;
        end else if (laf_state) begin
            w_dout_sel = SEL_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout <= '0;
        end else begin
            case (w_dout_sel)
                SEL_HEADER: r_dout <= r_header;
                SEL_DATA:   r_dout <= d_in;
                SEL_HOLD:   r_dout <= r_hold;
                default:    r_dout <= r_dout;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_header  <= '0;
            r_hdr_err <= 1'b0;
        end else begin
            if (w_hdr_seen && w_addr_ok) begin
                r_header <= d_in;
            end
            r_hdr_err <= w_hdr_seen & ~w_addr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold <= '0;
        end else if (ld_state && fifo_full) begin
            r_hold <= d_in;
        end
    end

    // Capture beats clear so a back-to-back detect cannot lose the checksum byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_chk         <= '0;
            r_parity_done <= 1'b0;
        end else if (w_chk_cap) begin
            r_chk         <= d_in;
            r_parity_done <= 1'b1;
        end else if (detect_add) begin
            r_chk         <= '0;
            r_parity_done <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            r_low_pkt_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_next;
        end
    end

`ifdef ROUTER_REG_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    // err stays high until the next packet, so count only its rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= '0;
        end else if (w_err_next && !r_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
    assign hdr_err       = r_hdr_err;

endmodule : router_reg_param
`default_nettype wire

// File: tb/tb_router_reg_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_router_reg_param
// Description : Self-checking bench; XOR and SUM instances share one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_router_reg_param;

`ifdef ROUTER_REG_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pkt_valid, fifo_full, detect_add, lfd_state;
    logic       ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0] d_in;

    logic [7:0] dout_x, dout_s, cnt_x, cnt_s;
    logic       pd_x, pd_s, lpv_x, lpv_s, err_x, err_s, he_x, he_s;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int mcnt_x   = 0;
    int mcnt_s   = 0;

    logic [7:0] pl[$];
    bit         st[$];
    logic [7:0] last_hdr = 8'h00;

    always #5 clk = ~clk;

    router_reg_param #(.CHK_MODE(0)) u_xor (
        .clk(clk), .rst(rst_n), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .d_in(d_in), .dout(dout_x), .parity_done(pd_x), .low_pkt_valid(lpv_x),
        .err(err_x), .hdr_err(he_x), .err_cnt(cnt_x)
    );

    router_reg_param #(.CHK_MODE(1)) u_sum (
        .clk(clk), .rst(rst_n), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .d_in(d_in), .dout(dout_s), .parity_done(pd_s), .low_pkt_valid(lpv_s),
        .err(err_s), .hdr_err(he_s), .err_cnt(cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pkt_valid = 0; fifo_full = 0; detect_add = 0; lfd_state = 0;
        ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0;
    endtask

    task automatic chk_dout(input string tag, input logic [7:0] exp);
        chk(tag, 32'(dout_x), 32'(exp));
        chk(tag, 32'(dout_s), 32'(exp));
    endtask

    task automatic chk_cnt(input string tag);
        chk(tag, 32'(cnt_x), CNT_EN ? 32'(mcnt_x) : 32'd0);
        chk(tag, 32'(cnt_s), CNT_EN ? 32'(mcnt_s) : 32'd0);
    endtask

    // Reference checksums straight from the packet contents.
    function automatic logic [7:0] model_xor(input logic [7:0] h);
        logic [7:0] a;
        a = h;
        foreach (pl[i]) a = a ^ pl[i];
        return a;
    endfunction

    function automatic logic [7:0] model_sum(input logic [7:0] h);
        int s;
        s = int'(h);
        foreach (pl[i]) s = s + int'(pl[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_payload_byte(input logic [7:0] b, input bit stall, inout logic [7:0] prev);
        if (stall) begin
            idle(); ld_state = 1; pkt_valid = 1; fifo_full = 1; d_in = b; tick();
            chk_dout("dout_stall_keep", prev);
            idle(); ld_state = 1; pkt_valid = 1; fifo_full = 1; full_state = 1; d_in = b; tick();
            chk_dout("dout_full_keep", prev);
            idle(); laf_state = 1; pkt_valid = 1; d_in = b; tick();
            chk_dout("dout_laf_hold", b);
        end else begin
            idle(); ld_state = 1; pkt_valid = 1; d_in = b; tick();
            chk_dout("dout_data", b);
        end
        prev = b;
    endtask

    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] cks);
        logic [7:0] prev;
        bit ex, es;
        ex = (cks != model_xor(hdr));
        es = (cks != model_sum(hdr));
        idle(); detect_add = 1; pkt_valid = 1; d_in = hdr; tick();
        chk("hdr_err_valid", 32'(he_x), 32'd0);
        idle(); lfd_state = 1; pkt_valid = 1; d_in = pl[0]; tick();
        chk_dout("dout_header", hdr);
        chk("pd_cleared", 32'(pd_x), 32'd0);
        last_hdr = hdr;
        prev = hdr;
        foreach (pl[i]) send_payload_byte(pl[i], st[i], prev);
        idle(); ld_state = 1; pkt_valid = 0; d_in = cks; tick();
        chk_dout("dout_cks", cks);
        chk("parity_done", 32'(pd_x), 32'd1);
        chk("low_pkt_valid", 32'(lpv_s), 32'd1);
        chk("err_pre", 32'(err_x), 32'd0);
        idle(); tick();
        if (ex && mcnt_x < 255) mcnt_x++;
        if (es && mcnt_s < 255) mcnt_s++;
        chk("err_xor", 32'(err_x), 32'(ex));
        chk("err_sum", 32'(err_s), 32'(es));
        chk_cnt("err_cnt");
        idle(); rst_int_reg = 1; tick();
        chk("lpv_cleared", 32'(lpv_x), 32'd0);
        idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, 32'(dout_x), 32'd0);
        chk({tag, "_pd"}, 32'(pd_s), 32'd0);
        chk({tag, "_lpv"}, 32'(lpv_x), 32'd0);
        chk({tag, "_err"}, 32'({err_x, err_s}), 32'd0);
        chk({tag, "_hdr_err"}, 32'(he_x), 32'd0);
        chk_cnt({tag, "_cnt"});
    endtask

    initial begin
        logic [7:0] hdr, cks;
        int n, sel;
        idle();
        d_in  = 8'h00;
        rst_n = 1'b0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Good XOR packet; SUM instance sees a mismatch on the same bytes.
        pl = '{8'h11, 8'h22, 8'h33}; st = '{0, 0, 0};
        send_packet(8'h0D, 8'h0D);

        // Corrupted checksum.
        send_packet(8'h0D, 8'h0C);

        // Out-of-range address: pulse, header register untouched.
        idle(); detect_add = 1; pkt_valid = 1; d_in = 8'h03; tick();
        chk("hdr_err_pulse", 32'(he_x), 32'd1);
        idle(); tick();
        chk("hdr_err_one_cycle", 32'(he_s), 32'd0);
        idle(); lfd_state = 1; pkt_valid = 1; tick();
        chk_dout("header_kept", last_hdr);
        idle(); tick();

        // FIFO full on 0x5A; the re-presented byte under full_state must not fold twice.
        pl = '{8'h11, 8'h5A, 8'h22}; st = '{0, 1, 0};
        send_packet(8'h05, model_xor(8'h05));

        // Wrap-around sum.
        pl = '{8'h20}; st = '{0};
        send_packet(8'hF1, 8'h11);

        // Randomized packets.
        for (int p = 0; p < 24; p++) begin
            hdr = 8'($urandom_range(0, 255));
            hdr[1:0] = 2'($urandom_range(0, 2));
            n = $urandom_range(1, 5);
            pl.delete(); st.delete();
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom_range(0, 255)));
                st.push_back($urandom_range(0, 3) == 0);
            end
            sel = $urandom_range(0, 2);
            cks = (sel == 0) ? model_xor(hdr) :
                  (sel == 1) ? model_sum(hdr) : 8'($urandom_range(0, 255));
            send_packet(hdr, cks);
        end

        // Leave err high, then reset in the middle of the next payload.
        pl = '{8'h44, 8'h55}; st = '{0, 0};
        send_packet(8'h12, model_xor(8'h12) ^ 8'hFF);
        idle(); detect_add = 1; pkt_valid = 1; d_in = 8'h22; tick();
        idle(); lfd_state = 1; pkt_valid = 1; tick();
        idle(); ld_state = 1; pkt_valid = 1; d_in = 8'h77; tick();
        rst_n = 1'b0;
        mcnt_x = 0;
        mcnt_s = 0;
        #2;
        chk_all_zero("async_reset");
        idle();
        tick();
        rst_n = 1'b1;
        tick();

        pl = '{8'h01, 8'h02, 8'h03}; st = '{0, 1, 0};
        send_packet(8'h0E, model_xor(8'h0E));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_router_reg_param
`default_nettype wire
